// File: rtl/itype_seq.sv
// Multi-cycle control sequencer for MIPS-style I-type ALU instructions.
// Walks FETCH -> DECODE -> EXEC -> WB and traps on illegal opcodes or a stalled fetch.
module itype_seq #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    input  logic        alu_ovf,
    output logic        ir_we,
    output logic [15:0] imm16,
    output logic [1:0]  ext_sel,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic        pc_we,
    output logic        exc_ovf,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_t;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_ADDU  = 3'd1,
        ALU_SLT   = 3'd2,
        ALU_SLTU  = 3'd3,
        ALU_AND   = 3'd4,
        ALU_OR    = 3'd5,
        ALU_XOR   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_t;

    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_t           cause_q, cause_d;

    ext_t             dec_ext;
    alu_t             dec_alu;
    logic             is_addi;
    logic             unused_rs;

    // The rs field is consumed by the datapath, not by this sequencer.
    assign unused_rs = ^ir_q[25:21];
    assign is_addi   = (ir_q[31:26] == OP_ADDI);

    // The low three opcode bits select the operation once DECODE has
    // confirmed the 001xxx prefix.
    always_comb begin
        dec_ext = EXT_ZERO;
        dec_alu = ALU_ADD;
        unique case (ir_q[28:26])
            3'b000: begin dec_ext = EXT_SIGN; dec_alu = ALU_ADD;   end
            3'b001: begin dec_ext = EXT_SIGN; dec_alu = ALU_ADDU;  end
            3'b010: begin dec_ext = EXT_SIGN; dec_alu = ALU_SLT;   end
            3'b011: begin dec_ext = EXT_SIGN; dec_alu = ALU_SLTU;  end
            3'b100: begin dec_ext = EXT_ZERO; dec_alu = ALU_AND;   end
            3'b101: begin dec_ext = EXT_ZERO; dec_alu = ALU_OR;    end
            3'b110: begin dec_ext = EXT_ZERO; dec_alu = ALU_XOR;   end
            3'b111: begin dec_ext = EXT_LUI;  dec_alu = ALU_PASSB; end
            default: begin dec_ext = EXT_ZERO; dec_alu = ALU_ADD;  end
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (ir_q[31:29] == 3'b001) begin
                    state_d = S_EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Outputs decode straight from the flops but are gated by rst so an
    // aborted instruction can never strobe rf_we or pc_we.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        ext_sel     = 2'b00;
        alu_op      = 3'd0;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        exc_ovf     = 1'b0;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        imm16       = 16'd0;
        rf_waddr    = 5'd0;
        if (!rst) begin
            imm16    = ir_q[15:0];
            rf_waddr = ir_q[20:16];
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    ext_sel     = dec_ext;
                    alu_op      = dec_alu;
                    alu_src_imm = 1'b1;
                end
                S_WB: begin
                    ext_sel     = dec_ext;
                    alu_op      = dec_alu;
                    alu_src_imm = 1'b1;
                    pc_we       = 1'b1;
                    exc_ovf     = is_addi && alu_ovf;
                    rf_we       = (ir_q[20:16] != 5'd0) && !(is_addi && alu_ovf);
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itype_seq.sv
// Scoreboard bench for itype_seq: expected WB results are queued at fetch
// and compared when the DUT strobes pc_we; traps and reset are checked directly.
module tb_itype_seq;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        alu_ovf = 1'b0;
    logic        ir_we;
    logic [15:0] imm16;
    logic [1:0]  ext_sel;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        pc_we;
    logic        exc_ovf;
    logic        trap;
    logic [1:0]  trap_cause;

    itype_seq #(.ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .alu_ovf     (alu_ovf),
        .ir_we       (ir_we),
        .imm16       (imm16),
        .ext_sel     (ext_sel),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .pc_we       (pc_we),
        .exc_ovf     (exc_ovf),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ext_sel;
        logic [2:0]  alu_op;
        logic [4:0]  waddr;
        logic [15:0] imm;
        logic        rf_we;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] ins, input logic ovf, input int waits);
        exp_t e;
        case (ins[31:26])
            6'b001000: begin e.ext_sel = 2'b01; e.alu_op = 3'd0; end
            6'b001001: begin e.ext_sel = 2'b01; e.alu_op = 3'd1; end
            6'b001010: begin e.ext_sel = 2'b01; e.alu_op = 3'd2; end
            6'b001011: begin e.ext_sel = 2'b01; e.alu_op = 3'd3; end
            6'b001100: begin e.ext_sel = 2'b00; e.alu_op = 3'd4; end
            6'b001101: begin e.ext_sel = 2'b00; e.alu_op = 3'd5; end
            6'b001110: begin e.ext_sel = 2'b00; e.alu_op = 3'd6; end
            default:   begin e.ext_sel = 2'b10; e.alu_op = 3'd7; end
        endcase
        e.waddr = ins[20:16];
        e.imm   = ins[15:0];
        e.exc   = (ins[31:26] == 6'b001000) && ovf;
        e.rf_we = (ins[20:16] != 5'd0) && !e.exc;
        e.lat   = waits + 4;
        return e;
    endfunction

    // Assumes the DUT is in FETCH; drives waits no-ack cycles, then the ack.
    task automatic run_instr(input logic [31:0] ins, input logic ovf, input int waits);
        exp_t e;
        int   cyc;
        bit   done;
        exp_q.push_back(predict(ins, ovf, waits));
        cyc = 0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk); imem_ack = 1'b0; alu_ovf = 1'b0; #1; cyc++;
            check("wait_req", imem_req, 1);
            check("wait_trap", trap, 0);
        end
        @(negedge clk); imem_ack = 1'b1; instr = ins; alu_ovf = 1'b0; #1; cyc++;
        check("fetch_irwe", ir_we, 1);
        check("fetch_req", imem_req, 1);
        done = 1'b0;
        for (int k = 1; k <= 6 && !done; k++) begin
            @(negedge clk); imem_ack = 1'b0; instr = $urandom; alu_ovf = ovf; #1; cyc++;
            check("busy_req", imem_req, 0);
            if (k == 1) check("decode_src", alu_src_imm, 0);
            if (k == 2) check("exec_src", alu_src_imm, 1);
            if (pc_we) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_ext_sel", ext_sel, e.ext_sel);
                    check("wb_alu_op", alu_op, e.alu_op);
                    check("wb_waddr", rf_waddr, e.waddr);
                    check("wb_imm16", imm16, e.imm);
                    check("wb_rf_we", rf_we, e.rf_we);
                    check("wb_exc_ovf", exc_ovf, e.exc);
                    check("wb_latency", cyc, e.lat);
                end
                done = 1'b1;
            end else begin
                check("early_rf_we", rf_we, 0);
                check("early_exc", exc_ovf, 0);
            end
        end
        if (!done) check("wb_seen", 0, 1);
    endtask

    // Leaves the DUT in its first post-reset FETCH cycle (one no-ack cycle).
    task automatic do_reset();
        @(negedge clk); rst = 1'b1; imem_ack = 1'b1; alu_ovf = 1'b1; instr = 32'hFFFF_FFFF; #1;
        check("rst_strobes", {imem_req, ir_we, rf_we, pc_we, exc_ovf, trap, alu_src_imm,
                              ext_sel, alu_op, trap_cause}, 0);
        check("rst_fields", {imm16, rf_waddr}, 0);
        @(negedge clk); rst = 1'b0; imem_ack = 1'b0; alu_ovf = 1'b0; #1;
        check("post_rst_req", imem_req, 1);
        check("post_rst_trap", {trap, trap_cause}, 0);
        check("post_rst_imm", imm16, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] illegal_list [2];
        illegal_list[0] = 32'h0000_0020;
        illegal_list[1] = 32'h4000_0000;

        do_reset();
        run_instr(32'h3405_ABCD, 1'b0, 0);     // ori
        run_instr(32'h2008_7FFF, 1'b1, 0);     // addi with overflow
        run_instr(32'h2008_7FFF, 1'b0, 2);     // addi, no overflow
        run_instr(32'h3C00_1234, 1'b0, 0);     // lui rt=0
        run_instr(32'h2862_FFFF, 1'b0, 1);     // slti
        run_instr(32'h2C41_8000, 1'b1, 0);     // sltiu, ovf ignored
        run_instr(32'h38E7_0F0F, 1'b0, 3);     // xori
        run_instr(32'h2529_FFFF, 1'b1, 0);     // addiu, ovf ignored
        run_instr(32'h3083_00F0, 1'b0, TO - 1); // ack on the last allowed cycle after WB

        // Ack arrives exactly on the timeout cycle: normal capture wins.
        do_reset();
        run_instr(32'h3405_ABCD, 1'b0, TO - 2);

        // No ack at all: trap with cause 10 after TO fetch cycles.
        do_reset();
        for (int i = 2; i <= TO; i++) begin
            @(negedge clk); imem_ack = 1'b0; #1;
            check("to_wait_req", imem_req, 1);
            check("to_wait_trap", trap, 0);
        end
        @(negedge clk); imem_ack = 1'b1; #1;
        check("to_trap", trap, 1);
        check("to_cause", trap_cause, 2'b10);
        check("to_req", imem_req, 0);
        check("to_irwe", ir_we, 0);

        // Illegal opcodes on both sides of the legal range.
        foreach (illegal_list[n]) begin
            do_reset();
            @(negedge clk); imem_ack = 1'b1; instr = illegal_list[n]; #1;
            check("ill_irwe", ir_we, 1);
            @(negedge clk); imem_ack = 1'b0; #1;
            check("ill_decode_trap", trap, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); imem_ack = 1'b1; alu_ovf = 1'b1; #1;
                check("ill_trap", {trap, trap_cause}, 3'b101);
                check("ill_quiet", {imem_req, ir_we, rf_we, pc_we, exc_ovf, alu_src_imm}, 0);
            end
        end

        // Reset while andi sits in EXEC aborts it with no write-back.
        do_reset();
        @(negedge clk); imem_ack = 1'b1; alu_ovf = 1'b0; instr = 32'h3083_00F0; #1;
        check("abort_irwe", ir_we, 1);
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        check("abort_exec", {alu_src_imm, ext_sel, alu_op}, {1'b1, 2'b00, 3'd4});
        rst = 1'b1; #1;
        check("abort_rst_outs", {imem_req, ir_we, rf_we, pc_we, exc_ovf, trap, alu_src_imm,
                                 ext_sel, alu_op, trap_cause, imm16, rf_waddr}, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("abort_no_wb", {rf_we, pc_we, alu_src_imm}, 0);
        check("abort_req", imem_req, 1);
        check("abort_ir_clear", rf_waddr, 0);
        run_instr(32'h3405_ABCD, 1'b0, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
